// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the single-port RAM responder.
package sp_ram_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_e;

   // Bit positions inside the err output.
   localparam int ERR_COLL = 0;
   localparam int ERR_ADDR = 1;
   localparam int ERR_BUSY = 2;
   localparam int ERR_W    = 3;

endpackage

// File: rtl/sp_ram_core.sv
// DEPTH x DATA_W storage with one shared address: write port plus 1-cycle registered read.
module sp_ram_core
   import sp_ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // Index width sized to the array; callers only present in-range addresses.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   assign idx = addr[IDX_W-1:0];

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Read register holds its value until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/sp_ram_responder.sv
// RAM responder: zero-fill FSM, request decode with error flags, read latency pipeline.
// rst_n is expected to be released synchronously to clk by the surrounding reset logic.
module sp_ram_responder
   import sp_ram_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int DEPTH          = 256,
   parameter int RD_LATENCY     = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              rden,
   input  logic              wren,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic              ready,
   output logic [ERR_W-1:0]  err
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam state_e          ST_RST  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_e            state, state_nx;
   logic [ADDR_W:0]   clr_addr, clr_addr_nx;
   logic              clr_we;

   logic              in_range, rd_fire, busy, coll, addr_bad;
   logic              req_we_d;
   logic [ADDR_W-1:0] req_addr_d;
   logic [DATA_W-1:0] req_data_d;

   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [DATA_W-1:0] core_q;
   logic [RD_LATENCY:0] vld_pipe;   // [0] = read issued to core, [k] = k edges later

   assign ready = (state == ST_RUN);

   // FSM state and clear counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RST;
         clr_addr <= '0;
      end else begin
         state    <= state_nx;
         clr_addr <= clr_addr_nx;
      end
   end

   // CLEAR writes one zero per cycle, then spends one more edge moving to RUN.
   always_comb begin
      state_nx    = state;
      clr_addr_nx = clr_addr;
      clr_we      = 1'b0;
      if (state == ST_CLEAR) begin
         if (clr_addr == DEPTH_L) begin
            state_nx = ST_RUN;
         end else begin
            clr_we      = 1'b1;
            clr_addr_nx = clr_addr + 1'b1;
         end
      end
   end

   // Request decode: busy wins over collision/range; read is dropped on collision.
   always_comb begin
      in_range   = ({1'b0, address} < DEPTH_L);
      busy       = !ready && (rden || wren);
      coll       = ready && rden && wren;
      addr_bad   = ready && (rden || wren) && !in_range;
      rd_fire    = ready && rden && !wren && in_range;
      req_we_d   = clr_we || (ready && wren && in_range);
      req_addr_d = clr_we ? clr_addr[ADDR_W-1:0] : address;
      req_data_d = clr_we ? '0 : data;
   end

   // Registered request into the core, error pulses and the read-valid shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_we   <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         err      <= '0;
         vld_pipe <= '0;
      end else begin
         req_we   <= req_we_d;
         req_addr <= req_addr_d;
         req_data <= req_data_d;
         err[ERR_COLL] <= coll;
         err[ERR_ADDR] <= addr_bad;
         err[ERR_BUSY] <= busy;
         vld_pipe <= {vld_pipe[RD_LATENCY-1:0], rd_fire};
      end
   end

   sp_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (req_we),
      .re    (vld_pipe[0]),
      .addr  (req_addr),
      .wdata (req_data),
      .rdata (core_q)
   );

   assign q_valid = vld_pipe[RD_LATENCY];

   generate
      if (RD_LATENCY == 1) begin : g_q_direct
         assign q = core_q;
      end else begin : g_q_dly
         logic [RD_LATENCY:2][DATA_W-1:0] dly;
         // Each stage loads only with a valid result so q holds between reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dly <= '0;
            end else begin
               if (vld_pipe[1]) dly[2] <= core_q;
               for (int k = 3; k <= RD_LATENCY; k++)
                  if (vld_pipe[k-1]) dly[k] <= dly[k-1];
            end
         end
         assign q = dly[RD_LATENCY];
      end
   endgenerate

endmodule

// File: tb/tb_sp_ram_responder.sv
// Directed bench: three responders (256/lat1/clear, 200/lat3/clear, 256/lat1/no-clear) share stimulus.
module tb_sp_ram_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rden, wren;
   logic [7:0] address, data;

   logic [7:0] a_q, b_q, c_q;
   logic       a_qv, b_qv, c_qv;
   logic       a_rdy, b_rdy, c_rdy;
   logic [2:0] a_err, b_err, c_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sp_ram_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .address(address), .data(data), .rden(rden), .wren(wren),
      .q(a_q), .q_valid(a_qv), .ready(a_rdy), .err(a_err));

   sp_ram_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .address(address), .data(data), .rden(rden), .wren(wren),
      .q(b_q), .q_valid(b_qv), .ready(b_rdy), .err(b_err));

   sp_ram_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .address(address), .data(data), .rden(rden), .wren(wren),
      .q(c_q), .q_valid(c_qv), .ready(c_rdy), .err(c_err));

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdat;
      logic [2:0] err;   // expected err right after this row's edge
      logic       qv;    // expected q_valid one edge later
      logic [7:0] q;     // expected q one edge later
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int rd, input int wr, input int a, input int d,
                               input int e, input int qv, input int qq);
      vec_t v;
      v.rd = rd[0]; v.wr = wr[0]; v.addr = a[7:0]; v.wdat = d[7:0];
      v.err = e[2:0]; v.qv = qv[0]; v.q = qq[7:0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      rden = r; wren = w; address = a; data = d;
   endtask

   initial begin
      drive(0, 0, 8'd0, 8'd0);
      repeat (3) tick;

      // Reset state
      chk("rst_a_ready", a_rdy, 0);
      chk("rst_a_q", a_q, 0);
      chk("rst_a_qv", a_qv, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_c_ready", c_rdy, 1);

      // Zero-fill timing, busy errors, no-clear instance usable at once
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 258; k++) begin
         drive(k == 10 || k == 20, k == 20, 8'd3, 8'h5A);
         tick;
         chk("fill_a_ready", a_rdy, (k >= 257));
         chk("fill_b_ready", b_rdy, (k >= 201));
         if (k == 10) begin
            chk("busy_a_err", a_err, 3'b100);
            chk("busy_b_err", b_err, 3'b100);
            chk("norun_c_err", c_err, 3'b000);
         end
         if (k == 11) begin
            chk("norun_c_qv", c_qv, 1);
            chk("busy_a_qv", a_qv, 0);
         end
         if (k == 20) begin
            chk("busy_prec_a_err", a_err, 3'b100);
            chk("coll_c_err", c_err, 3'b001);
         end
         if (k == 21) chk("coll_c_qv", c_qv, 0);
      end

      // Table-driven run on instance A (latency 1)
      tbl.push_back(mk(1, 0, 5, 0, 0, 1, 8'h00));
      for (int i = 10; i <= 20; i++) tbl.push_back(mk(0, 1, i, i, 0, 0, 8'h00));
      for (int i = 10; i <= 20; i++) tbl.push_back(mk(1, 0, i, 0, 0, 1, i));
      tbl.push_back(mk(1, 1, 7, 8'hA5, 3'b001, 0, 20));
      tbl.push_back(mk(1, 0, 7, 0, 0, 1, 8'hA5));
      tbl.push_back(mk(0, 1, 9, 8'h3C, 0, 0, 8'hA5));
      tbl.push_back(mk(1, 0, 9, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(0, 1, 255, 8'h77, 0, 0, 8'h3C));
      tbl.push_back(mk(1, 0, 255, 0, 0, 1, 8'h77));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h77));
      for (int i = 0; i <= tbl.size(); i++) begin
         if (i < tbl.size()) drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdat);
         else                drive(0, 0, 8'd0, 8'd0);
         tick;
         if (i < tbl.size()) chk($sformatf("tbl%0d_err", i), a_err, tbl[i].err);
         if (i > 0) begin
            chk($sformatf("tbl%0d_qv", i - 1), a_qv, tbl[i-1].qv);
            chk($sformatf("tbl%0d_q", i - 1), a_q, tbl[i-1].q);
         end
      end
      drive(0, 0, 8'd0, 8'd0);
      repeat (4) tick;

      // Instance B latency 3: read of 12 appears exactly 3 edges after the sample
      drive(1, 0, 8'd12, 8'd0);
      tick;
      chk("lat3_qv_e0", b_qv, 0);
      drive(0, 0, 8'd0, 8'd0);
      tick; chk("lat3_qv_e1", b_qv, 0);
      tick; chk("lat3_qv_e2", b_qv, 0);
      tick; chk("lat3_qv_e3", b_qv, 1); chk("lat3_q_e3", b_q, 12);
      tick; chk("lat3_qv_e4", b_qv, 0); chk("lat3_q_hold", b_q, 12);

      // Instance B DEPTH=200 range checks
      drive(0, 1, 8'd250, 8'h11);
      tick;
      chk("range_wr_b_err", b_err, 3'b010);
      chk("range_wr_a_err", a_err, 3'b000);
      drive(1, 0, 8'd250, 8'd0);
      tick;
      chk("range_rd_b_err", b_err, 3'b010);
      drive(0, 0, 8'd0, 8'd0);
      for (int j = 1; j <= 3; j++) begin
         tick;
         chk("range_rd_b_qv", b_qv, 0);
      end
      chk("range_rd_b_qhold", b_q, 12);
      drive(1, 0, 8'd200, 8'd0);
      tick;
      chk("range_200_err", b_err, 3'b010);
      drive(1, 0, 8'd199, 8'd0);
      tick;
      chk("range_199_err", b_err, 3'b000);
      drive(0, 0, 8'd0, 8'd0);
      for (int j = 1; j <= 3; j++) begin
         tick;
         chk("range_199_qv", b_qv, (j == 3));
      end
      chk("range_199_q", b_q, 0);

      // Reset mid-read, then reset mid-clear
      drive(1, 0, 8'd12, 8'd0);
      tick;
      drive(0, 0, 8'd0, 8'd0);
      tick;
      rst_n = 1'b0;
      #1;
      chk("flush_b_qv", b_qv, 0);
      chk("flush_b_q", b_q, 0);
      chk("flush_a_ready", a_rdy, 0);
      chk("flush_a_q", a_q, 0);
      repeat (2) tick;
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick;
         chk("flush_b_qv_run", b_qv, 0);
      end
      chk("midclr_a_ready", a_rdy, 0);
      rst_n = 1'b0;
      tick;
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 258; k++) begin
         tick;
         chk("refill_a_ready", a_rdy, (k >= 257));
         chk("refill_b_ready", b_rdy, (k >= 201));
         chk("refill_b_qv", b_qv, 0);
      end

      // Previously written word is zero again after the restarted fill
      drive(1, 0, 8'd15, 8'd0);
      tick;
      drive(0, 0, 8'd0, 8'd0);
      tick;
      chk("refill_rd15_qv", a_qv, 1);
      chk("refill_rd15_q", a_q, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
